ui_menu_fsm: RTL
================

UI_MENU_FSM -- requirements
Module: ui_menu_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port mouse_x, input, 10 bits: cursor column in 640x480 screen pixels.
REQ-004 SHALL have port mouse_y, input, 10 bits: cursor row in 640x480 screen pixels.
REQ-005 SHALL have port mouse_left, input, 1 bit: left button level.
REQ-006 SHALL have port stage_clear, input, 1 bit: one-cycle pulse, current stage cleared.
REQ-007 SHALL have port stage_fail, input, 1 bit: one-cycle pulse, instant failure.
REQ-008 SHALL have port hit, input, 1 bit: one-cycle pulse, player damaged (STAGE3 only).
REQ-009 SHALL have port state, output, 4 bits: current screen (TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8, HELP=9).
REQ-010 SHALL have port play_valid, output, 4 bits: bit k set means stage k is unlocked (k = 1..3); bit 0 is unused.
REQ-011 SHALL have port life, output, 2 bits: remaining lives.
REQ-012 SHALL have port stage_start, output, 1 bit: one-cycle pulse on entry to any STAGEk.

Function
REQ-013 SHALL derive half-resolution coordinates px = mouse_x>>1 and py = mouse_y>>1; all button rectangles SHALL be half-open [lo,hi) in px/py.
REQ-014 SHALL generate click = mouse_left & ~mouse_left_q, where mouse_left_q is mouse_left registered one cycle; coordinates SHALL be sampled in the same cycle as click.
REQ-015 SHALL take a click-driven transition at the clock edge on which click=1; held button SHALL NOT retrigger.
REQ-016 SHALL, in TITLE with px in [120,200), apply these transitions:
- py in [120,140): go to STAGE1.
- py in [150,170) and play_valid[2]: go to STAGE2.
- py in [180,200) and play_valid[3]: go to STAGE3.
- py in [210,230): go to HELP.
- locked stage button: no transition.
REQ-017 SHALL, in SUCCESS1/SUCCESS2 with px in [120,200), apply these transitions:
- py in [140,160) (next): go to STAGE2/STAGE3 respectively.
- py in [180,200) (back): go to TITLE.
REQ-018 SHALL, in SUCCESS3, go to STAFF on click with px in [120,200) and py in [150,170).
REQ-019 SHALL, in FAIL with px in [120,200), apply these transitions:
- py in [140,160) (retry): go to the STAGE held in register last_stage.
- py in [180,200) (back): go to TITLE.
REQ-020 SHALL, in STAFF with px in [120,200) and py in [180,200), go to TITLE; in HELP with px in [120,200) and py in [200,220), go to TITLE.
REQ-021 SHALL ignore clicks in STAGE states and ignore stage_clear/stage_fail/hit outside STAGE states.
REQ-022 SHALL, in STAGEk, go to SUCCESSk on stage_clear, else go to FAIL on stage_fail; stage_clear SHALL win when both are asserted.
REQ-023 SHALL set life=3 on every STAGE3 entry; in STAGE3, hit SHALL decrement life, and hit with life==1 SHALL set life=0 and go to FAIL; stage_clear SHALL win over a simultaneous hit, and life SHALL NOT change in that cycle.
REQ-024 SHALL set play_valid[2] on entry to SUCCESS1 and play_valid[3] on entry to SUCCESS2; bits SHALL clear only on rst.
REQ-025 SHALL load last_stage on every STAGE entry.
REQ-026 SHALL assert stage_start in the first cycle state equals a STAGE value, including retry re-entry.
REQ-027 SHALL treat unused state encodings 10-15 as TITLE on the next cycle.

Reset
REQ-028 SHALL, on rst, set state=TITLE, play_valid=4'b0010, life=3, stage_start=0, last_stage=STAGE1, and mouse_left_q=1 so that a button held through reset produces no click.
REQ-029 SHALL let rst override all inputs, including an in-flight click or stage event.

Structure
REQ-030 SHALL place state encodings and all button rectangle bounds in a shared package ui_pkg, so that the draw logic and this block share one layout.
REQ-031 SHALL implement the rectangle compare in one combinational sub-module ui_hit_rect (inputs px, py, x0, x1, y0, y1; output in).

Verification
REQ-032 SHALL verify reset then click at (260,260): next cycle state=2 and stage_start=1 for one cycle.
REQ-033 SHALL verify TITLE click at (260,320) with play_valid=0010: state stays 0; after a STAGE1 clear, SUCCESS1, back at (260,380), then the same click, state=4.
REQ-034 SHALL verify that in STAGE3 three hit pulses give life 3->2->1->0 and state=8, then retry at (260,300) gives state=6 and life=3.
REQ-035 SHALL verify that stage_clear and stage_fail asserted together in STAGE2 give state=5 and play_valid=1110.
REQ-036 SHALL verify that mouse_left held for 100 cycles across a SUCCESS1 next at (260,300) produces exactly one transition (state=4, not beyond).
REQ-037 SHALL verify that rst asserted while state=9 gives state=0 and play_valid=0010 on the next edge.

Source files
------------

// File: rtl/ui_pkg.sv
// Shared menu layout: screen encodings and button rectangles (half-resolution px/py),
// used by both the menu FSM and the draw logic so the two never disagree.
package ui_pkg;

    typedef enum logic [3:0] {
        S_TITLE    = 4'd0,
        S_STAFF    = 4'd1,
        S_STAGE1   = 4'd2,
        S_SUCCESS1 = 4'd3,
        S_STAGE2   = 4'd4,
        S_SUCCESS2 = 4'd5,
        S_STAGE3   = 4'd6,
        S_SUCCESS3 = 4'd7,
        S_FAIL     = 4'd8,
        S_HELP     = 4'd9
    } state_t;

    typedef struct packed {
        logic [8:0] x0;
        logic [8:0] x1;
        logic [8:0] y0;
        logic [8:0] y1;
    } rect_t;

    localparam logic [8:0] BTN_X0 = 9'd120;
    localparam logic [8:0] BTN_X1 = 9'd200;

    // Button ids; NEXT doubles as FAIL retry, BACK doubles as STAFF back.
    localparam int B_STAGE1    = 0;
    localparam int B_STAGE2    = 1;
    localparam int B_STAGE3    = 2;
    localparam int B_HELP      = 3;
    localparam int B_NEXT      = 4;
    localparam int B_BACK      = 5;
    localparam int B_STAFF     = 6;
    localparam int B_HELP_BACK = 7;
    localparam int NUM_BTN     = 8;

    function automatic rect_t btn_rect(input int id);
        rect_t r;
        r.x0 = BTN_X0;
        r.x1 = BTN_X1;
        case (id)
            B_STAGE1:    begin r.y0 = 9'd120; r.y1 = 9'd140; end
            B_STAGE2:    begin r.y0 = 9'd150; r.y1 = 9'd170; end
            B_STAGE3:    begin r.y0 = 9'd180; r.y1 = 9'd200; end
            B_HELP:      begin r.y0 = 9'd210; r.y1 = 9'd230; end
            B_NEXT:      begin r.y0 = 9'd140; r.y1 = 9'd160; end
            B_BACK:      begin r.y0 = 9'd180; r.y1 = 9'd200; end
            B_STAFF:     begin r.y0 = 9'd150; r.y1 = 9'd170; end
            default:     begin r.y0 = 9'd200; r.y1 = 9'd220; end
        endcase
        return r;
    endfunction

    function automatic logic is_stage(input state_t s);
        return (s == S_STAGE1) || (s == S_STAGE2) || (s == S_STAGE3);
    endfunction

endpackage

// File: rtl/ui_hit_rect.sv
// Half-open rectangle containment test: x0 <= px < x1 and y0 <= py < y1.
module ui_hit_rect (
    input  logic [8:0] px,
    input  logic [8:0] py,
    input  logic [8:0] x0,
    input  logic [8:0] x1,
    input  logic [8:0] y0,
    input  logic [8:0] y1,
    output logic       in
);
    assign in = (px >= x0) && (px < x1) && (py >= y0) && (py < y1);
endmodule

// File: rtl/ui_menu_fsm.sv
// Menu/stage screen sequencer: mouse-click navigation between screens, stage
// results, stage unlocks and the STAGE3 life counter.
module ui_menu_fsm
    import ui_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] mouse_x,
    input  logic [9:0] mouse_y,
    input  logic       mouse_left,
    input  logic       stage_clear,
    input  logic       stage_fail,
    input  logic       hit,
    output logic [3:0] state,
    output logic [3:0] play_valid,
    output logic [1:0] life,
    output logic       stage_start
);
    state_t               state_q, state_n, last_stage;
    logic [1:0]           life_n;
    logic                 mouse_left_q, click, entering;
    logic [8:0]           px, py;
    logic [NUM_BTN-1:0]   in_btn;

    assign px    = mouse_x[9:1];
    assign py    = mouse_y[9:1];
    assign click = mouse_left & ~mouse_left_q;
    assign state = state_q;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        localparam rect_t R = btn_rect(i);
        ui_hit_rect u_rect (
            .px(px), .py(py),
            .x0(R.x0), .x1(R.x1), .y0(R.y0), .y1(R.y1),
            .in(in_btn[i])
        );
    end

    always_comb begin
        state_n = state_q;
        life_n  = life;
        case (state_q)
            S_TITLE: if (click) begin
                if (in_btn[B_STAGE1])                       state_n = S_STAGE1;
                else if (in_btn[B_STAGE2] && play_valid[2]) state_n = S_STAGE2;
                else if (in_btn[B_STAGE3] && play_valid[3]) state_n = S_STAGE3;
                else if (in_btn[B_HELP])                    state_n = S_HELP;
            end
            S_STAGE1: if (stage_clear) state_n = S_SUCCESS1;
                      else if (stage_fail) state_n = S_FAIL;
            S_STAGE2: if (stage_clear) state_n = S_SUCCESS2;
                      else if (stage_fail) state_n = S_FAIL;
            S_STAGE3: if (stage_clear) state_n = S_SUCCESS3;
                      else begin
                          if (hit && life != 2'd0) life_n = life - 2'd1;
                          if (stage_fail || (hit && life == 2'd1)) state_n = S_FAIL;
                      end
            S_SUCCESS1: if (click) begin
                if (in_btn[B_NEXT])      state_n = S_STAGE2;
                else if (in_btn[B_BACK]) state_n = S_TITLE;
            end
            S_SUCCESS2: if (click) begin
                if (in_btn[B_NEXT])      state_n = S_STAGE3;
                else if (in_btn[B_BACK]) state_n = S_TITLE;
            end
            S_SUCCESS3: if (click && in_btn[B_STAFF]) state_n = S_STAFF;
            S_FAIL: if (click) begin
                if (in_btn[B_NEXT])      state_n = last_stage;
                else if (in_btn[B_BACK]) state_n = S_TITLE;
            end
            S_STAFF: if (click && in_btn[B_BACK])     state_n = S_TITLE;
            S_HELP:  if (click && in_btn[B_HELP_BACK]) state_n = S_TITLE;
            default: state_n = S_TITLE;
        endcase
        // Retry always comes from FAIL, so a STAGE entry is always a state change.
        entering = is_stage(state_n) && (state_n != state_q);
        if (entering && state_n == S_STAGE3) life_n = 2'd3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_TITLE;
            play_valid   <= 4'b0010;
            life         <= 2'd3;
            stage_start  <= 1'b0;
            last_stage   <= S_STAGE1;
            mouse_left_q <= 1'b1;
        end else begin
            state_q      <= state_n;
            life         <= life_n;
            stage_start  <= entering;
            mouse_left_q <= mouse_left;
            if (entering) last_stage <= state_n;
            if (state_n == S_SUCCESS1 && state_q != S_SUCCESS1) play_valid[2] <= 1'b1;
            if (state_n == S_SUCCESS2 && state_q != S_SUCCESS2) play_valid[3] <= 1'b1;
        end
    end
endmodule
